// File: rtl/debug_mem_port_if.sv
// debug_mem_port_if -- signal bundle for the debug memory port.
//   Debug side : dbg_ce/dbg_we/dbg_addr/dbg_wdata in; dbg_rdata, dbg_rdata_ready,
//                dbg_done, dbg_err, dbg_overrun out.
//   Bus side   : cpu_bus_busy, mem_ack, mem_rdata in; bus_own, mem_req, mem_we,
//                mem_addr, mem_wdata out.
//   fsm_state  : debug view of the port FSM (0 IDLE, 1 WAIT_BUS, 2 ACCESS, 3 RESP).
// Handshake: dbg_ce is a one-cycle strobe that is accepted only when the port
// is idle. mem_req is held, with mem_we/mem_addr/mem_wdata stable, until the
// cycle in which mem_ack is seen or the timeout aborts the access. mem_ack is
// only meaningful while mem_req is high.
// modport slave is the port itself; modport master is its environment.
interface debug_mem_port_if;
  logic        dbg_ce;
  logic        dbg_we;
  logic [63:0] dbg_addr;
  logic [63:0] dbg_wdata;
  logic [63:0] dbg_rdata;
  logic        dbg_rdata_ready;
  logic        dbg_done;
  logic        dbg_err;
  logic        dbg_overrun;
  logic        cpu_bus_busy;
  logic        bus_own;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic [1:0]  fsm_state;

  modport slave (
    input  dbg_ce, dbg_we, dbg_addr, dbg_wdata, cpu_bus_busy, mem_ack, mem_rdata,
    output dbg_rdata, dbg_rdata_ready, dbg_done, dbg_err, dbg_overrun,
           bus_own, mem_req, mem_we, mem_addr, mem_wdata, fsm_state
  );

  modport master (
    output dbg_ce, dbg_we, dbg_addr, dbg_wdata, cpu_bus_busy, mem_ack, mem_rdata,
    input  dbg_rdata, dbg_rdata_ready, dbg_done, dbg_err, dbg_overrun,
           bus_own, mem_req, mem_we, mem_addr, mem_wdata, fsm_state
  );
endinterface

// File: rtl/debug_mem_port.sv
// debug_mem_port -- lets a debug controller perform single 64-bit reads and
// writes on the shared memory bus. A request is captured on dbg_ce, waits for
// the CPU to release the bus, issues one memory access (aborted after TIMEOUT
// cycles without mem_ack) and reports completion with a one-cycle dbg_done.
// Ports:
//   clk   : sole clock, rising edge
//   rst_p : synchronous active-high reset
//   bus   : debug_mem_port_if.slave (debug request/response + memory bus)
// Parameters:
//   TIMEOUT  : max cycles mem_req is held without mem_ack (1..255)
//   ERR_DATA : read data returned when an access times out
// All outputs are registered; none depends combinationally on dbg_* inputs.
module debug_mem_port #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [63:0] ERR_DATA = 64'hDEAD_BEEF_DEAD_BEEF
) (
  input logic             clk,
  input logic             rst_p,
  debug_mem_port_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_BUS = 2'd1,
    ACCESS   = 2'd2,
    RESP     = 2'd3
  } state_t;

  // Count value in the final ACCESS cycle that may still be acked.
  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic        req_we;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [63:0] rdata_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic        bus_own_q;
  logic        done_q;
  logic        ready_q;
  logic        err_q;
  logic        overrun_q;

  always_ff @(posedge clk) begin
    if (rst_p) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      req_we    <= 1'b0;
      addr_q    <= 64'd0;
      wdata_q   <= 64'd0;
      rdata_q   <= 64'd0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      bus_own_q <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      ready_q <= 1'b0;

      // A strobe outside IDLE (RESP included) is dropped and only flagged.
      if (bus.dbg_ce && state != IDLE) overrun_q <= 1'b1;

      case (state)
        IDLE: begin
          if (bus.dbg_ce) begin
            req_we  <= bus.dbg_we;
            addr_q  <= bus.dbg_addr & ~64'h7;
            wdata_q <= bus.dbg_wdata;
            state   <= WAIT_BUS;
          end
        end
        WAIT_BUS: begin
          if (!bus.cpu_bus_busy) begin
            bus_own_q <= 1'b1;
            mem_req_q <= 1'b1;
            mem_we_q  <= req_we;
            cnt       <= 8'd0;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          // mem_ack is checked first so an ack in the expiry cycle wins.
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            if (!req_we) rdata_q <= bus.mem_rdata;
            done_q    <= 1'b1;
            ready_q   <= !req_we;
            state     <= RESP;
          end else if (cnt == LAST_CNT) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            if (!req_we) rdata_q <= ERR_DATA;
            err_q     <= 1'b1;
            done_q    <= 1'b1;
            ready_q   <= !req_we;
            cnt       <= cnt + 8'd1;
            state     <= RESP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: begin
          bus_own_q <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.dbg_rdata       = rdata_q;
  assign bus.dbg_rdata_ready = ready_q;
  assign bus.dbg_done        = done_q;
  assign bus.dbg_err         = err_q;
  assign bus.dbg_overrun     = overrun_q;
  assign bus.bus_own         = bus_own_q;
  assign bus.mem_req         = mem_req_q;
  assign bus.mem_we          = mem_we_q;
  assign bus.mem_addr        = addr_q;
  assign bus.mem_wdata       = wdata_q;
  assign bus.fsm_state       = state;

endmodule
